// File: rtl/subtract_seq_ctrl_if.sv
// Signal bundle between the grouping-stage subtract sequencer, its centroid/neighbor
// buffers, the subtract module and the downstream result consumer.
interface subtract_seq_ctrl_if #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int PE_ROW           = 16,
   parameter int K_NEIGHBOR       = 16,
   parameter int ADDR_WIDTH       = 10,
   parameter int CIDX_WIDTH       = 6
);
   localparam int W  = INPUT_DATA_WIDTH * PE_ROW;
   localparam int KW = (K_NEIGHBOR > 1) ? $clog2(K_NEIGHBOR) : 1;

   logic                  start;
   logic [CIDX_WIDTH-1:0] cfg_num_centroid;
   logic                  busy;
   logic                  done_all;
   logic                  cen_rd_en;
   logic [ADDR_WIDTH-1:0] cen_rd_addr;
   logic [W-1:0]          cen_rd_data;
   logic                  nbr_rd_en;
   logic [ADDR_WIDTH-1:0] nbr_rd_addr;
   logic [W-1:0]          nbr_rd_data;
   logic                  is_centroid;
   logic                  is_neighbor;
   logic [W-1:0]          din_centroid;
   logic [W-1:0]          din_neighbor;
   logic                  sub_done;
   logic                  out_valid;
   logic                  out_ready;
   logic [CIDX_WIDTH-1:0] out_cidx;
   logic [KW-1:0]         out_kidx;
   logic                  out_last;

   modport master (
      input  start, cfg_num_centroid, cen_rd_data, nbr_rd_data, sub_done, out_ready,
      output busy, done_all, cen_rd_en, cen_rd_addr, nbr_rd_en, nbr_rd_addr,
             is_centroid, is_neighbor, din_centroid, din_neighbor,
             out_valid, out_cidx, out_kidx, out_last
   );

   modport slave (
      output start, cfg_num_centroid, cen_rd_data, nbr_rd_data, sub_done, out_ready,
      input  busy, done_all, cen_rd_en, cen_rd_addr, nbr_rd_en, nbr_rd_addr,
             is_centroid, is_neighbor, din_centroid, din_neighbor,
             out_valid, out_cidx, out_kidx, out_last
   );
endinterface

// File: rtl/subtract_seq_ctrl.sv
// Sequencer for subtract_module32: loads one centroid, streams its K neighbors with the
// required is_neighbor hold, waits for sub_done and hands each result downstream.
module subtract_seq_ctrl #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int PE_ROW           = 16,
   parameter int K_NEIGHBOR       = 16,
   parameter int NB_HOLD          = 4,
   parameter int ADDR_WIDTH       = 10,
   parameter int CIDX_WIDTH       = 6
) (
   input logic                 clk,
   input logic                 rst,
   subtract_seq_ctrl_if.master bus
);
   localparam int W  = INPUT_DATA_WIDTH * PE_ROW;
   localparam int KW = (K_NEIGHBOR > 1) ? $clog2(K_NEIGHBOR) : 1;
   localparam int HW = (NB_HOLD > 1) ? $clog2(NB_HOLD) : 1;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_C_RD   = 4'd1;
   localparam logic [3:0] S_C_CAP  = 4'd2;
   localparam logic [3:0] S_C_LD   = 4'd3;
   localparam logic [3:0] S_N_RD   = 4'd4;
   localparam logic [3:0] S_N_CAP  = 4'd5;
   localparam logic [3:0] S_N_HOLD = 4'd6;
   localparam logic [3:0] S_N_WAIT = 4'd7;
   localparam logic [3:0] S_N_OUT  = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   logic [3:0]            r_state;
   logic [CIDX_WIDTH-1:0] r_num;
   logic [CIDX_WIDTH-1:0] r_c;
   logic [KW-1:0]         r_k;
   logic [HW-1:0]         r_hold;
   logic [W-1:0]          r_din_cen;
   logic [W-1:0]          r_din_nbr;
   logic                  w_last_k;
   logic                  w_last_c;

   assign w_last_k = (r_k == KW'(K_NEIGHBOR - 1));
   assign w_last_c = (r_c == r_num - CIDX_WIDTH'(1));

   // NOTE: the wide data registers are reset as well so an aborted run leaves no stale vector on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_num     <= '0;
         r_c       <= '0;
         r_k       <= '0;
         r_hold    <= '0;
         r_din_cen <= '0;
         r_din_nbr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_num   <= bus.cfg_num_centroid;
                  r_c     <= '0;
                  r_k     <= '0;
                  r_state <= (bus.cfg_num_centroid == '0) ? S_DONE : S_C_RD;
               end
            end
            S_C_RD:  r_state <= S_C_CAP;
            S_C_CAP: begin
               r_din_cen <= bus.cen_rd_data;
               r_state   <= S_C_LD;
            end
            S_C_LD: begin
               r_k     <= '0;
               r_state <= S_N_RD;
            end
            S_N_RD:  r_state <= S_N_CAP;
            S_N_CAP: begin
               r_din_nbr <= bus.nbr_rd_data;
               r_hold    <= '0;
               r_state   <= S_N_HOLD;
            end
            S_N_HOLD: begin
               if (r_hold == HW'(NB_HOLD - 1)) r_state <= S_N_WAIT;
               else                            r_hold  <= r_hold + 1'b1;
            end
            S_N_WAIT: if (bus.sub_done) r_state <= S_N_OUT;
            // No new read is issued until the result is taken, so the subtract output stays put.
            S_N_OUT: begin
               if (bus.out_ready) begin
                  if (!w_last_k) begin
                     r_k     <= r_k + 1'b1;
                     r_state <= S_N_RD;
                  end else if (!w_last_c) begin
                     r_c     <= r_c + 1'b1;
                     r_state <= S_C_RD;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done_all     = (r_state == S_DONE);
   assign bus.cen_rd_en    = (r_state == S_C_RD);
   assign bus.cen_rd_addr  = ADDR_WIDTH'(r_c);
   assign bus.nbr_rd_en    = (r_state == S_N_RD);
   // Linear neighbor address wraps modulo 2**ADDR_WIDTH.
   assign bus.nbr_rd_addr  = ADDR_WIDTH'(r_c) * ADDR_WIDTH'(K_NEIGHBOR) + ADDR_WIDTH'(r_k);
   assign bus.is_centroid  = (r_state == S_C_LD);
   assign bus.is_neighbor  = (r_state == S_N_HOLD);
   assign bus.din_centroid = r_din_cen;
   assign bus.din_neighbor = r_din_nbr;
   assign bus.out_valid    = (r_state == S_N_OUT);
   assign bus.out_cidx     = r_c;
   assign bus.out_kidx     = r_k;
   assign bus.out_last     = (r_state == S_N_OUT) && w_last_k && w_last_c;
endmodule
